// File: rtl/link_tx.sv
// link_tx: transmitter end of the router physical channel.
// Flits are staged in one FIFO per virtual channel; a per-VC FSM holds a VC
// from HEAD to TAIL, and one flit per cycle goes out on odata/ovalid/ovch.
// Optional feature macro: LINK_TX_RR_EN (round-robin arbitration between VCs;
// when undefined, fixed priority with VC0 over VC1).
//
// Handshake: upstream may write a flit to VC v whenever ordy[v] is high in the
// same cycle as ivalid; a write with ordy[ivch] low is dropped and flags err.
// Downstream accepts a flit on VC v only when irdy[v] was high in the cycle the
// flit was granted; ovalid is a one-cycle pulse per flit with no back-pressure.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 30
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module link_tx #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [`DATAW:0]   idata,
  input  logic              ivalid,
  input  logic [`VCHW:0]    ivch,
  output logic [`VCH:0]     ordy,
  output logic [`DATAW:0]   odata,
  output logic              ovalid,
  output logic [`VCHW:0]    ovch,
  input  logic [`VCH:0]     irdy,
  input  logic [`VCH:0]     ilck,
  output logic [`VCH:0]     busy,
  output logic              err
);

  localparam int NVC   = `VCH + 1;
  localparam int TYPEW = `TYPE_MSB - `TYPE_LSB + 1;
  localparam logic [PTRW+1:0] FULL_CNT = (PTRW+2)'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VC = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  logic [`DATAW:0]  mem       [NVC][DEPTH];
  logic [PTRW:0]    wptr      [NVC];
  logic [PTRW:0]    rptr      [NVC];
  logic [PTRW+1:0]  count     [NVC];
  // Per-VC FSM state, kept as a plain array so checkers can bind to it.
  logic [1:0]       vc_state  [NVC];
  logic [1:0]       state_nxt [NVC];
  logic [`DATAW:0]  head_flit [NVC];
  logic [TYPEW-1:0] head_type [NVC];

  logic [NVC-1:0]   nonempty;
  logic [NVC-1:0]   eligible;
  logic [NVC-1:0]   discard;
  logic [NVC-1:0]   head_err;
  logic [NVC-1:0]   grant;
  logic [NVC-1:0]   push;
  logic [NVC-1:0]   pop;
  logic             drop;
  logic             any_grant;
  logic [`VCHW:0]   gnt_vc;

  function automatic logic is_head(input logic [TYPEW-1:0] t);
    return (t == `TYPE_HEAD) || (t == `TYPE_HEADTAIL);
  endfunction

  // FIFO status, eligibility and write acceptance per VC.
  always_comb begin
    drop = 1'b0;
    for (int v = 0; v < NVC; v++) begin
      head_flit[v] = mem[v][rptr[v]];
      head_type[v] = head_flit[v][`TYPE_MSB:`TYPE_LSB];
      nonempty[v]  = (count[v] != '0);
      ordy[v]      = (count[v] < FULL_CNT);
      busy[v]      = (vc_state[v] != ST_IDLE);
      push[v]      = ivalid && (ivch == (`VCHW+1)'(v)) && ordy[v];
      discard[v]   = (vc_state[v] == ST_IDLE) && nonempty[v] && !is_head(head_type[v]);
      case (vc_state[v])
        ST_WAIT_VC: eligible[v] = nonempty[v] && !ilck[v] && irdy[v];
        ST_ACTIVE:  eligible[v] = nonempty[v] && irdy[v];
        default:    eligible[v] = 1'b0;
      endcase
      if (ivalid && (ivch == (`VCHW+1)'(v)) && !ordy[v]) drop = 1'b1;
    end
  end

`ifdef LINK_TX_RR_EN
  logic [`VCHW:0] rr_ptr;
  logic [`VCHW:0] rr_idx;

  // Round-robin pick: search eligible VCs starting at the pointer.
  always_comb begin
    grant     = '0;
    gnt_vc    = '0;
    any_grant = 1'b0;
    rr_idx    = '0;
    for (int i = 0; i < NVC; i++) begin
      rr_idx = rr_ptr + (`VCHW+1)'(i);
      if (!any_grant && eligible[rr_idx]) begin
        grant[rr_idx] = 1'b1;
        gnt_vc        = rr_idx;
        any_grant     = 1'b1;
      end
    end
  end

  // Pointer moves to the VC after the one just granted.
  always_ff @(posedge clk) begin
    if (rst_) rr_ptr <= '0;
    else if (any_grant) rr_ptr <= gnt_vc + (`VCHW+1)'(1);
  end
`else
  // Fixed priority pick: lowest-numbered eligible VC wins.
  always_comb begin
    grant     = '0;
    gnt_vc    = '0;
    any_grant = 1'b0;
    for (int i = 0; i < NVC; i++) begin
      if (!any_grant && eligible[i]) begin
        grant[i]  = 1'b1;
        gnt_vc    = (`VCHW+1)'(i);
        any_grant = 1'b1;
      end
    end
  end
`endif

  // Per-VC next state; a head seen mid-packet is forwarded but flagged.
  always_comb begin
    pop = grant | discard;
    for (int v = 0; v < NVC; v++) begin
      state_nxt[v] = vc_state[v];
      head_err[v]  = 1'b0;
      case (vc_state[v])
        ST_IDLE: begin
          if (nonempty[v] && is_head(head_type[v])) state_nxt[v] = ST_WAIT_VC;
        end
        ST_WAIT_VC: begin
          if (grant[v]) begin
            if (head_type[v] == `TYPE_HEADTAIL) state_nxt[v] = ST_IDLE;
            else                                state_nxt[v] = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (grant[v]) begin
            if (head_type[v] == `TYPE_TAIL) state_nxt[v] = ST_IDLE;
            head_err[v] = is_head(head_type[v]);
          end
        end
        default: state_nxt[v] = ST_IDLE;
      endcase
    end
  end

  // Staging storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NVC; v++) begin
      if (push[v]) mem[v][wptr[v]] <= idata;
    end
  end

  // FIFO pointers/counts and FSM state; a same-cycle push+pop keeps count.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NVC; v++) begin
      if (rst_) begin
        wptr[v]     <= '0;
        rptr[v]     <= '0;
        count[v]    <= '0;
        vc_state[v] <= ST_IDLE;
      end else begin
        vc_state[v] <= state_nxt[v];
        if (push[v]) wptr[v] <= wptr[v] + (PTRW+1)'(1);
        if (pop[v])  rptr[v] <= rptr[v] + (PTRW+1)'(1);
        case ({push[v], pop[v]})
          2'b10:   count[v] <= count[v] + (PTRW+2)'(1);
          2'b01:   count[v] <= count[v] - (PTRW+2)'(1);
          default: count[v] <= count[v];
        endcase
      end
    end
  end

  // Link register: granted flit goes out next edge; ovch holds when idle.
  always_ff @(posedge clk) begin
    if (rst_) begin
      odata  <= '0;
      ovalid <= 1'b0;
      ovch   <= '0;
      err    <= 1'b0;
    end else begin
      ovalid <= any_grant;
      odata  <= any_grant ? head_flit[gnt_vc] : '0;
      if (any_grant) ovch <= gnt_vc;
      if (drop || (|discard) || (|head_err)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_link_tx.sv
// tb_link_tx: scoreboard bench for link_tx. Driven flits that must reach the
// link are queued in exp_q; a negedge monitor pops and compares each output.
`ifndef DATAW
`define DATAW 31
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module tb_link_tx;
  localparam int DEPTH = 4;
  localparam int W     = (`DATAW + 1) + (`VCHW + 1);
  localparam logic [1:0] T_BODY = `TYPE_BODY;
  localparam logic [1:0] T_HEAD = `TYPE_HEAD;
  localparam logic [1:0] T_TAIL = `TYPE_TAIL;
  localparam logic [1:0] T_HT   = `TYPE_HEADTAIL;

  logic             clk = 1'b0;
  logic             rst_;
  logic [`DATAW:0]  idata;
  logic             ivalid;
  logic [`VCHW:0]   ivch;
  logic [`VCH:0]    ordy;
  logic [`DATAW:0]  odata;
  logic             ovalid;
  logic [`VCHW:0]   ovch;
  logic [`VCH:0]    irdy;
  logic [`VCH:0]    ilck;
  logic [`VCH:0]    busy;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];
  int out_cyc[$];

  link_tx #(.DEPTH(DEPTH), .PTRW(1)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .ordy(ordy), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .irdy(irdy), .ilck(ilck), .busy(busy), .err(err)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [`DATAW:0] mk_flit(input logic [1:0] t, input logic [`DATAW-2:0] pl);
    return {t, pl};
  endfunction

  // Scoreboard monitor: every link flit must match the queue head.
  always @(negedge clk) begin
    if (!rst_ && ovalid) begin
      n_out++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("link_unexpected", 64'(exp_q.size()), 64'd1);
      else check("link_flit", 64'({ovch, odata}), 64'(exp_q.pop_front()));
    end
  end

  task automatic do_reset();
    rst_   = 1'b1;
    ivalid = 1'b0;
    idata  = '0;
    ivch   = '0;
    irdy   = '1;
    ilck   = '0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
    exp_q.delete();
    out_cyc.delete();
    n_out = 0;
  endtask

  // Write one flit; the write edge is the posedge this task waits for.
  task automatic send_flit(input logic [`VCHW:0] vc, input logic [1:0] t,
                           input logic [`DATAW-2:0] pl, input bit expect_out);
    logic [`DATAW:0] f;
    f = mk_flit(t, pl);
    @(negedge clk);
    idata  = f;
    ivalid = 1'b1;
    ivch   = vc;
    if (expect_out) exp_q.push_back({vc, f});
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    idata  = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int drop_cyc;
    bit seen;
    logic [`DATAW:0] f1;

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_ordy",   64'(ordy),   64'(2'b11));
    check("rst_ovalid", 64'(ovalid), 64'd0);
    check("rst_odata",  64'(odata),  64'd0);
    check("rst_ovch",   64'(ovch),   64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_err",    64'(err),    64'd0);

    // Single HEADTAIL on VC0: on the link two cycles after the write edge.
    f1 = mk_flit(T_HT, 30'(32'h0123_4567 + $urandom_range(0, 255)));
    send_flit(1'b0, T_HT, f1[`DATAW-2:0], 1'b1);
    @(negedge clk);
    check("t1_ovalid_n0", 64'(ovalid), 64'd0);
    @(negedge clk);
    check("t1_ovalid_n1", 64'(ovalid), 64'd0);
    check("t1_busy_wait", 64'(busy[0]), 64'd1);
    @(negedge clk);
    check("t1_ovalid_n2", 64'(ovalid), 64'd1);
    check("t1_ovch",      64'(ovch),   64'd0);
    check("t1_odata",     64'(odata),  64'(f1));
    check("t1_busy_idle", 64'(busy[0]), 64'd0);
    wait_drain("t1_drain");

    // 4-flit packet on VC1 with irdy[1] low for 3 cycles after the 2nd flit.
    do_reset();
    fork
      begin
        send_flit(1'b1, T_HEAD, 30'h100, 1'b1);
        send_flit(1'b1, T_BODY, 30'h101, 1'b1);
        send_flit(1'b1, T_BODY, 30'h102, 1'b1);
        send_flit(1'b1, T_TAIL, 30'h103, 1'b1);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk);
          #1;
          if (n_out >= 2) seen = 1'b1;
        end
        check("t2_two_flits_seen", 64'(seen), 64'd1);
        irdy[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 irdy[1] = 1'b1;
      end
    join
    wait_drain("t2_drain");
    check("t2_count", 64'(out_cyc.size()), 64'd4);
    if (out_cyc.size() == 4) begin
      check("t2_gap_b1", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
      check("t2_gap_stall", 64'(out_cyc[2] - out_cyc[1]), 64'd4);
      check("t2_gap_tail", 64'(out_cyc[3] - out_cyc[2]), 64'd1);
    end

    // HEAD held by ilck[0] for 5 cycles, sent the cycle after it falls.
    do_reset();
    ilck[0] = 1'b1;
    send_flit(1'b0, T_HT, 30'h2AA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_locked_idle", 64'(ovalid), 64'd0);
    end
    @(posedge clk);
    #1 ilck[0] = 1'b0;
    drop_cyc = cyc;
    wait_drain("t3_drain");
    check("t3_count", 64'(out_cyc.size()), 64'd1);
    if (out_cyc.size() == 1) check("t3_latency", 64'(out_cyc[0] - drop_cyc), 64'd1);

    // Both VCs eligible at once.
    do_reset();
    irdy = 2'b00;
    send_flit(1'b0, T_HEAD, 30'h300, 1'b0);
    send_flit(1'b0, T_TAIL, 30'h301, 1'b0);
    send_flit(1'b1, T_HEAD, 30'h310, 1'b0);
    send_flit(1'b1, T_TAIL, 30'h311, 1'b0);
`ifdef LINK_TX_RR_EN
    exp_q.push_back({1'b0, mk_flit(T_HEAD, 30'h300)});
    exp_q.push_back({1'b1, mk_flit(T_HEAD, 30'h310)});
    exp_q.push_back({1'b0, mk_flit(T_TAIL, 30'h301)});
    exp_q.push_back({1'b1, mk_flit(T_TAIL, 30'h311)});
`else
    exp_q.push_back({1'b0, mk_flit(T_HEAD, 30'h300)});
    exp_q.push_back({1'b0, mk_flit(T_TAIL, 30'h301)});
    exp_q.push_back({1'b1, mk_flit(T_HEAD, 30'h310)});
    exp_q.push_back({1'b1, mk_flit(T_TAIL, 30'h311)});
`endif
    @(negedge clk);
    irdy = 2'b11;
    wait_drain("t4_drain");
    check("t4_count", 64'(n_out), 64'd4);

    // Fill VC0 while blocked, overflow once, then drain exactly DEPTH flits.
    do_reset();
    irdy = 2'b10;
    send_flit(1'b0, T_HEAD, 30'(32'h400 + $urandom_range(0, 15)), 1'b1);
    for (int i = 0; i < DEPTH - 2; i++)
      send_flit(1'b0, T_BODY, 30'(32'h410 + i), 1'b1);
    send_flit(1'b0, T_TAIL, 30'h4FF, 1'b1);
    @(negedge clk);
    check("t5_ordy0_full", 64'(ordy[0]), 64'd0);
    check("t5_ordy1_free", 64'(ordy[1]), 64'd1);
    check("t5_err_before", 64'(err), 64'd0);
    send_flit(1'b0, T_BODY, 30'h4EE, 1'b0);
    @(negedge clk);
    check("t5_err_overflow", 64'(err), 64'd1);
    base = n_out;
    irdy = 2'b11;
    wait_drain("t5_drain");
    check("t5_emitted", 64'(n_out - base), 64'(DEPTH));

    // BODY into an idle VC1 is discarded; a following HEADTAIL goes out.
    do_reset();
    send_flit(1'b1, T_BODY, 30'h500, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_link", 64'(ovalid), 64'd0);
    end
    check("t6_err", 64'(err), 64'd1);
    check("t6_busy", 64'(busy[1]), 64'd0);
    send_flit(1'b1, T_HT, 30'h501, 1'b1);
    wait_drain("t6_drain");
    check("t6_count", 64'(n_out), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
